// File: rtl/coin_pkg.sv
// coin_pkg: shared state encoding, default coin table and greedy change selection.
package coin_pkg;

    localparam int MAX_N = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_OK  = 3'd1,
        WAIT_ERR = 3'd2,
        ERROR    = 3'd3,
        CHANGE   = 3'd4
    } state_t;

    localparam logic [27:0] COIN_VALS_D = {7'd25, 7'd10, 7'd5, 7'd1};

    // Coins are stored in ascending value order, so the highest fitting index is the greedy choice.
    function automatic logic [MAX_N-1:0] greedy_pick(input logic [MAX_N-1:0] fits);
        greedy_pick = '0;
        for (int i = 0; i < MAX_N; i++)
            if (fits[i]) greedy_pick = MAX_N'(1) << i;
    endfunction

endpackage

// File: rtl/coin_accum_ctrl_if.sv
// coin_accum_ctrl_if: coin, vend and change-dispenser signals between the controller and its host.
interface coin_accum_ctrl_if #(
    parameter int NCOIN = 4,
    parameter int BAL_W = 7
);
    logic [NCOIN-1:0] coin_sel;
    logic [BAL_W-1:0] price;
    logic             vend_req;
    logic             chg_req;
    logic             chg_ready;
    logic             err_clr;
    logic [BAL_W-1:0] balance;
    logic             chg_valid;
    logic [NCOIN-1:0] chg_coin;
    logic             vend_ok;
    logic             vend_deny;
    logic             full;
    logic             error;
    logic             busy;

    modport master (
        input  coin_sel, price, vend_req, chg_req, chg_ready, err_clr,
        output balance, chg_valid, chg_coin, vend_ok, vend_deny, full, error, busy
    );

    modport slave (
        output coin_sel, price, vend_req, chg_req, chg_ready, err_clr,
        input  balance, chg_valid, chg_coin, vend_ok, vend_deny, full, error, busy
    );
endinterface

// File: rtl/key_edge_sync.sv
// key_edge_sync: two-flop synchroniser for a raw key plus a one-cycle falling-edge pulse.
module key_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);
    logic s1, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {s1, level, prev} <= {3{RST_VAL}};
        else        {s1, level, prev} <= {din, s1, level};
    end

    assign fall = prev & ~level;
endmodule

// File: rtl/coin_accum_ctrl.sv
// coin_accum_ctrl: coin balance accumulator with vend deduction and greedy one-coin-per-handshake change.
module coin_accum_ctrl
    import coin_pkg::*;
#(
    parameter int                     NCOIN     = 4,
    parameter int                     BAL_W     = 7,
    parameter int                     MAX_BAL   = 99,
    parameter logic [NCOIN*BAL_W-1:0] COIN_VALS = COIN_VALS_D
) (
    input logic               MAX10_CLK1_50,
    input logic               rst_n,
    input logic               key_ins_n,
    coin_accum_ctrl_if.master bus
);
    localparam logic [BAL_W:0] MAX_B = (BAL_W+1)'(MAX_BAL);

    state_t           state;
    logic             key_lvl, press;
    logic [BAL_W-1:0] coin_val, chg_val, diff;
    logic [BAL_W:0]   sum;
    logic [NCOIN-1:0] fits, pick;

    key_edge_sync #(.RST_VAL(1'b1)) u_key (
        .clk   (MAX10_CLK1_50),
        .rst_n (rst_n),
        .din   (key_ins_n),
        .level (key_lvl),
        .fall  (press)
    );

    always_comb begin
        coin_val = '0;
        chg_val  = '0;
        fits     = '0;
        for (int i = 0; i < NCOIN; i++) begin
            fits[i] = COIN_VALS[i*BAL_W +: BAL_W] <= bus.balance;
            if (bus.coin_sel[i]) coin_val = coin_val | COIN_VALS[i*BAL_W +: BAL_W];
        end
        pick = NCOIN'(greedy_pick(MAX_N'(fits)));
        for (int i = 0; i < NCOIN; i++)
            if (pick[i]) chg_val = chg_val | COIN_VALS[i*BAL_W +: BAL_W];
        sum  = {1'b0, bus.balance} + {1'b0, coin_val};
        diff = bus.balance - bus.price;
    end

    assign bus.chg_coin = bus.chg_valid ? pick : '0;
    assign bus.error    = (state == WAIT_ERR) || (state == ERROR);
    assign bus.busy     = state != IDLE;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.balance   <= '0;
            bus.chg_valid <= 1'b0;
            bus.vend_ok   <= 1'b0;
            bus.vend_deny <= 1'b0;
            bus.full      <= 1'b0;
        end else begin
            bus.vend_ok   <= 1'b0;
            bus.vend_deny <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        if (!$onehot0(bus.coin_sel)) state <= WAIT_ERR;
                        else begin
                            state <= WAIT_OK;
                            if (sum <= MAX_B) bus.balance <= sum[BAL_W-1:0];
                            else              bus.full    <= 1'b1;
                        end
                    end else if (bus.vend_req) begin
                        if (bus.balance >= bus.price) begin
                            bus.balance <= diff;
                            bus.vend_ok <= 1'b1;
                            if ({1'b0, diff} < MAX_B) bus.full <= 1'b0;
                        end else bus.vend_deny <= 1'b1;
                    end else if (bus.chg_req && bus.balance != '0) begin
                        state         <= CHANGE;
                        bus.chg_valid <= 1'b1;
                    end
                end
                WAIT_OK:  if (key_lvl) state <= IDLE;
                WAIT_ERR: if (key_lvl) state <= ERROR;
                ERROR:    if (bus.err_clr) state <= IDLE;
                CHANGE: begin
                    if (bus.chg_ready) begin
                        bus.balance <= bus.balance - chg_val;
                        if (bus.balance == chg_val) begin
                            state         <= IDLE;
                            bus.chg_valid <= 1'b0;
                            bus.full      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
